// File: rtl/fdu_heartbeat_gen.sv
// fdu_heartbeat_gen: turns software kick strobes into the 3-bit Gray-code
// heartbeat checked by the FDU watchdog.
//   - Each code is held for at least HOLD_CYCLES clocks.
//   - Kicks that arrive during a hold are queued, up to MAX_PENDING deep.
//   - If no kick arrives for KICK_TIMEOUT cycles, the heartbeat freezes so the
//     watchdog reports the unit unhealthy. Only enable=0 releases the freeze.
// Optional build macro: FAULT_INJECT_EN adds fault_skip. When fault_skip is
// high on the cycle an advance is taken, fdu jumps two sequence steps.
// Ports:
//   clk, reset_n   clock; asynchronous active-low reset
//   enable         1 = heartbeat running, 0 = hold fdu at 000
//   kick           one-cycle request for one code advance
//   clr_flags      one-cycle strobe that clears kick_overflow
//   fault_skip     (FAULT_INJECT_EN only) double-step on the next advance
//   fdu[2:0]       registered Gray-code heartbeat
//   pending[1:0]   queued kicks that have not been applied yet
//   stalled        kick timeout reached; heartbeat frozen
//   kick_overflow  sticky; a kick was dropped because the queue was full
module fdu_heartbeat_gen #(
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned MAX_PENDING  = 3,
  parameter int unsigned KICK_TIMEOUT = 3000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       kick,
  input  logic       clr_flags,
`ifdef FAULT_INJECT_EN
  input  logic       fault_skip,
`endif
  output logic [2:0] fdu,
  output logic [1:0] pending,
  output logic       stalled,
  output logic       kick_overflow
);

  localparam int unsigned DW = $clog2(HOLD_CYCLES);
  localparam int unsigned TW = 24;
  localparam int unsigned PW = 2;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(KICK_TIMEOUT - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_READY, S_STALL} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_fdu, w_fdu_nxt;
  logic [PW-1:0] r_pending, w_pending_nxt;
  logic          r_stalled, w_stalled_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_skip;
  logic          w_timeout;
  logic          w_at_gate;
  logic          w_take;
  logic          w_ovf_set;

`ifdef FAULT_INJECT_EN
  assign w_skip = fault_skip;
`else
  assign w_skip = 1'b0;
`endif

  // Advance a Gray code by one (or two) sequence steps via binary.
  function automatic logic [2:0] gray_step(input logic [2:0] g, input logic two);
    logic [2:0] b;
    logic [2:0] nb;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    nb   = b + (two ? 3'd2 : 3'd1);
    return nb ^ {1'b0, nb[2:1]};
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_fdu     <= 3'b000;
      r_pending <= '0;
      r_stalled <= 1'b0;
      r_ovf     <= 1'b0;
      r_dwell   <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fdu     <= w_fdu_nxt;
      r_pending <= w_pending_nxt;
      r_stalled <= w_stalled_nxt;
      r_ovf     <= w_ovf_nxt;
      r_dwell   <= w_dwell_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  // Next-state logic: dwell gating, kick queue, stall detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_fdu_nxt     = r_fdu;
    w_pending_nxt = r_pending;
    w_stalled_nxt = r_stalled;
    w_dwell_nxt   = r_dwell;
    w_timer_nxt   = r_timer;
    w_timeout     = 1'b0;
    w_at_gate     = 1'b0;
    w_take        = 1'b0;
    w_ovf_set     = 1'b0;

    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_fdu_nxt     = 3'b000;
      w_pending_nxt = '0;
      w_stalled_nxt = 1'b0;
      w_dwell_nxt   = '0;
      w_timer_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_DWELL;
          w_fdu_nxt     = 3'b000;
          w_pending_nxt = '0;
          w_stalled_nxt = 1'b0;
          w_dwell_nxt   = '0;
          w_timer_nxt   = '0;
        end
        S_DWELL, S_READY: begin
          // Any kick, even one that gets dropped, restarts the timeout.
          w_timeout   = !kick && (r_timer == TMR_LAST);
          w_timer_nxt = kick ? '0 : r_timer + TW'(1);
          w_at_gate   = (r_state == S_READY) || (r_dwell == DWELL_LAST);
          if (w_timeout) begin
            // Stall wins over an advance due in the same cycle.
            w_state_nxt   = S_STALL;
            w_stalled_nxt = 1'b1;
          end else begin
            w_take = w_at_gate && (kick || (r_pending != '0));
            if (w_take) begin
              w_fdu_nxt   = gray_step(r_fdu, w_skip);
              w_dwell_nxt = '0;
              w_state_nxt = S_DWELL;
            end else if (r_state == S_DWELL) begin
              if (w_at_gate) w_state_nxt = S_READY;
              else           w_dwell_nxt = r_dwell + DW'(1);
            end
            // A kick that coincides with a consume leaves the queue unchanged.
            if (kick && !w_take) begin
              if (r_pending == PEND_MAX) w_ovf_set = 1'b1;
              else                       w_pending_nxt = r_pending + PW'(1);
            end else if (!kick && w_take) begin
              w_pending_nxt = r_pending - PW'(1);
            end
          end
        end
        S_STALL: begin
          w_state_nxt = S_STALL;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // A new overflow has priority over a clear in the same cycle.
    w_ovf_nxt = w_ovf_set ? 1'b1 : (clr_flags ? 1'b0 : r_ovf);
  end

  assign fdu           = r_fdu;
  assign pending       = r_pending;
  assign stalled       = r_stalled;
  assign kick_overflow = r_ovf;

endmodule

// File: tb/tb_fdu_heartbeat_gen.sv
module tb_fdu_heartbeat_gen;

  localparam int HOLD = 4;
  localparam int MAXP = 3;
  localparam int KT   = 50;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       kick;
  logic       clr_flags;
  logic       fault_skip;
  logic [2:0] fdu;
  logic [1:0] pending;
  logic       stalled;
  logic       kick_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  fdu_heartbeat_gen #(
    .HOLD_CYCLES (HOLD),
    .MAX_PENDING (MAXP),
    .KICK_TIMEOUT(KT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .kick         (kick),
    .clr_flags    (clr_flags),
`ifdef FAULT_INJECT_EN
    .fault_skip   (fault_skip),
`endif
    .fdu          (fdu),
    .pending      (pending),
    .stalled      (stalled),
    .kick_overflow(kick_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position in the heartbeat sequence, queue depth,
  // cycles spent on the current code, cycles since the last kick.
  int gseq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  bit m_active, m_frozen, m_ovf;
  int m_idx, m_q, m_age, m_tmr;

  task automatic model_reset();
    m_active = 0; m_frozen = 0; m_ovf = 0;
    m_idx = 0; m_q = 0; m_age = 0; m_tmr = 0;
  endtask

  task automatic model_edge(bit en, bit k, bit c, bit sk);
    bit set_o = 0;
    bit take;
    if (!en) begin
      m_active = 0; m_frozen = 0; m_idx = 0; m_q = 0; m_age = 0; m_tmr = 0;
    end else if (!m_active) begin
      m_active = 1; m_age = 0; m_tmr = 0;
    end else if (!m_frozen) begin
      if (!k && m_tmr == KT - 1) begin
        m_frozen = 1;
      end else begin
        m_tmr = k ? 0 : m_tmr + 1;
        take = (m_age >= HOLD - 1) && (k || m_q > 0);
        if (take) begin
          m_idx = (m_idx + (sk ? 2 : 1)) % 8;
          m_age = 0;
        end else if (m_age < HOLD - 1) begin
          m_age++;
        end
        m_q = m_q + int'(k) - int'(take);
        if (m_q > MAXP) begin
          m_q = MAXP;
          set_o = 1;
        end
      end
    end
    if (set_o) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_fdu", int'(fdu), gseq[m_idx]);
    chk("model_pending", int'(pending), m_q);
    chk("model_stalled", int'(stalled), int'(m_frozen));
    chk("model_overflow", int'(kick_overflow), int'(m_ovf));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(bit en, bit k, bit c, bit sk);
    enable = en; kick = k; clr_flags = c; fault_skip = sk;
    @(posedge clk);
    #1;
    model_edge(en, k, c, sk);
    chk_model();
  endtask

  typedef struct {
    bit en; bit k; bit c;
    int e_fdu; int e_pend; bit e_st; bit e_ov;
  } vec_t;
  vec_t tbl[24];

  initial begin
    int quiet;
    bit en, k, c, sk;

    // Queue fill, overflow, full-queue kick on a consume, clear, READY, disable.
    tbl[0]  = '{1,0,0, 0,0,0,0};
    tbl[1]  = '{1,1,0, 0,1,0,0};
    tbl[2]  = '{1,1,0, 0,2,0,0};
    tbl[3]  = '{1,1,0, 0,3,0,0};
    tbl[4]  = '{1,1,0, 1,3,0,0};
    tbl[5]  = '{1,1,0, 1,3,0,1};
    tbl[6]  = '{1,0,0, 1,3,0,1};
    tbl[7]  = '{1,0,0, 1,3,0,1};
    tbl[8]  = '{1,0,0, 3,2,0,1};
    tbl[9]  = '{1,0,1, 3,2,0,0};
    tbl[10] = '{1,0,0, 3,2,0,0};
    tbl[11] = '{1,0,0, 3,2,0,0};
    tbl[12] = '{1,0,0, 2,1,0,0};
    tbl[13] = '{1,0,0, 2,1,0,0};
    tbl[14] = '{1,0,0, 2,1,0,0};
    tbl[15] = '{1,0,0, 2,1,0,0};
    tbl[16] = '{1,0,0, 6,0,0,0};
    tbl[17] = '{1,0,0, 6,0,0,0};
    tbl[18] = '{1,0,0, 6,0,0,0};
    tbl[19] = '{1,0,0, 6,0,0,0};
    tbl[20] = '{1,0,0, 6,0,0,0};
    tbl[21] = '{1,0,0, 6,0,0,0};
    tbl[22] = '{1,1,0, 7,0,0,0};
    tbl[23] = '{0,0,0, 0,0,0,0};

    reset_n = 1'b0; enable = 0; kick = 0; clr_flags = 0; fault_skip = 0;
    model_reset();
    #2;
    chk("reset_fdu", int'(fdu), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_stalled", int'(stalled), 0);
    chk("reset_overflow", int'(kick_overflow), 0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].en, tbl[i].k, tbl[i].c, 0);
      chk($sformatf("tbl%0d_fdu", i), int'(fdu), tbl[i].e_fdu);
      chk($sformatf("tbl%0d_pending", i), int'(pending), tbl[i].e_pend);
      chk($sformatf("tbl%0d_stalled", i), int'(stalled), int'(tbl[i].e_st));
      chk($sformatf("tbl%0d_overflow", i), int'(kick_overflow), int'(tbl[i].e_ov));
    end

    // Stall exactly KT cycles after the last kick, frozen at 011.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("stall_first_adv", int'(fdu), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("stall_at_011", int'(fdu), 3);
    for (int i = 0; i < KT - 1; i++) step(1, 0, 0, 0);
    chk("stall_not_early", int'(stalled), 0);
    step(1, 0, 0, 0);
    chk("stall_on_time", int'(stalled), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    chk("stall_frozen_fdu", int'(fdu), 3);
    chk("stall_frozen_pending", int'(pending), 0);
    step(0, 0, 0, 0);
    chk("stall_exit_fdu", int'(fdu), 0);
    chk("stall_exit_flag", int'(stalled), 0);

    // Reach fdu=110 with two kicks queued, then reset mid-cycle.
    step(1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("pre_areset_fdu", int'(fdu), 6);
    chk("pre_areset_pending", int'(pending), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_fdu", int'(fdu), 0);
    chk("areset_pending", int'(pending), 0);
    chk("areset_stalled", int'(stalled), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Randomized run with quiet stretches long enough to trigger stalls.
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      if (quiet == 0 && $urandom_range(199) == 0) quiet = 60;
      en = ($urandom_range(39) != 0);
      k  = (quiet == 0) && ($urandom_range(2) == 0);
      c  = ($urandom_range(15) == 0);
`ifdef FAULT_INJECT_EN
      sk = ($urandom_range(7) == 0);
`else
      sk = 0;
`endif
      if (quiet > 0) quiet--;
      step(en, k, c, sk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
